watch_mode_ctrl: RTL

Mode controller for the multifunction watch. It owns the one-hot mode register (WATCH / COOK_TIMER / STOPWATCH) and routes the debounced button edges to exactly one sub-function. It also preempts to COOK_TIMER on a cook alarm, drives the pulsed buzzer, and auto-returns to WATCH after inactivity. It sits between the four button_cntr instances and the watch, cook_timer and stop_watch2 instances; its mode output drives the FND value mux.

---
 rtl/watch_defs.sv | 16 +
 rtl/ms_tick_gen.sv | 32 +++
 rtl/watch_mode_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/watch_defs.sv
// Shared definitions for the multifunction watch: one-hot mode encodings
// and a counter-width helper used by the timers.
package watch_defs;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] WATCH      = 3'b001;
    localparam logic [MODE_W-1:0] COOK_TIMER = 3'b010;
    localparam logic [MODE_W-1:0] STOPWATCH  = 3'b100;

    // Width needed to hold 0..n-1, never less than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond tick prescaler: counts 0..CLK_HZ/1000-1 and pulses tick for
// one cycle at terminal count. With CLK_HZ/1000 == 1 the tick is constant 1.
module ms_tick_gen
    import watch_defs::*;
#(
    parameter int CLK_HZ = 100000000
) (
    input  logic clk,
    input  logic reset_p,
    output logic tick
);

    localparam int DIV = (CLK_HZ / 1000 < 1) ? 1 : CLK_HZ / 1000;
    localparam int W   = cnt_w(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    assign tick = (cnt == LAST);

    // Prescaler count, wrapping at terminal count.
    always_ff @(posedge clk) begin
        if (reset_p) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/watch_mode_ctrl.sv
// Mode controller for the multifunction watch.
// Owns the one-hot mode register, routes debounced button edges to the
// active sub-function, preempts to COOK_TIMER on a cook alarm, drives the
// pulsed buzzer and (with AUTO_RETURN_EN defined) returns to WATCH after
// an inactivity timeout.
//
// state      | meaning
// -----------+-----------------------------------------------
// WATCH      | time-of-day display, buttons go to watch
// COOK_TIMER | cook timer display, buttons go to cook_timer
// STOPWATCH  | stopwatch display, buttons go to stop_watch2
module watch_mode_ctrl
    import watch_defs::*;
#(
    parameter int CLK_HZ          = 100000000,
    parameter int IDLE_TIMEOUT_MS = 30000,
    parameter int BUZ_HALF_MS     = 500
) (
    input  logic              clk,
    input  logic              reset_p,
    input  logic [3:0]        btn_pedge,
    input  logic              alarm_in,
    input  logic              sw_running,
    output logic [MODE_W-1:0] mode,
    output logic [2:0]        watch_btn,
    output logic [2:0]        cook_btn,
    output logic [2:0]        stop_btn,
    output logic              alarm_ack,
    output logic              buz
);

    localparam int BW = cnt_w(BUZ_HALF_MS);
    localparam logic [BW-1:0] BUZ_LAST = BW'(BUZ_HALF_MS - 1);

    logic [MODE_W-1:0] mode_q;
    logic [MODE_W-1:0] mode_d;
    logic              alarm_d;
    logic              alarm_rise;
    logic              mode_adv;
    logic              tick;
    logic              timeout;
    logic [BW-1:0]     buz_cnt;

    assign alarm_rise = alarm_in & ~alarm_d;
    // The mode button is locked out while the alarm holds COOK_TIMER.
    assign mode_adv   = btn_pedge[3] & ~alarm_in;
    assign mode       = mode_q;

    ms_tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_tick (
        .clk     (clk),
        .reset_p (reset_p),
        .tick    (tick)
    );

    // Mode register and alarm-edge history.
    always_ff @(posedge clk) begin
        if (reset_p) begin
            mode_q  <= WATCH;
            alarm_d <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            alarm_d <= alarm_in;
        end
    end

    // Next mode: alarm rise, then mode button, then idle timeout.
    always_comb begin
        mode_d = mode_q;
        if (alarm_rise) begin
            mode_d = COOK_TIMER;
        end else begin
            case (mode_q)
                WATCH: begin
                    if (mode_adv) mode_d = COOK_TIMER;
                end
                COOK_TIMER: begin
                    if (mode_adv)     mode_d = STOPWATCH;
                    else if (timeout) mode_d = WATCH;
                end
                STOPWATCH: begin
                    if (mode_adv)     mode_d = WATCH;
                    else if (timeout) mode_d = WATCH;
                end
                default: mode_d = WATCH;
            endcase
        end
    end

    // Button routing to the active sub-function; the alarm steals the
    // cook buttons and turns them into an acknowledge.
    always_comb begin
        watch_btn = 3'b000;
        cook_btn  = 3'b000;
        stop_btn  = 3'b000;
        alarm_ack = 1'b0;
        if (!reset_p) begin
            case (mode_q)
                WATCH:      watch_btn = btn_pedge[2:0];
                COOK_TIMER: if (!alarm_in) cook_btn = btn_pedge[2:0];
                STOPWATCH:  stop_btn = btn_pedge[2:0];
                default:    ;
            endcase
            alarm_ack = alarm_in & (|btn_pedge[2:0]);
        end
    end

`ifdef AUTO_RETURN_EN
    localparam int IW = cnt_w(IDLE_TIMEOUT_MS);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT_MS - 1);

    logic [IW-1:0] idle_cnt;
    logic          count_en;

    // Inactivity only accrues away from WATCH, with no alarm, and not
    // while the stopwatch is running.
    assign count_en = (mode_q != WATCH) & ~alarm_in
                    & ~((mode_q == STOPWATCH) & sw_running);
    // A button in the terminal cycle counts as activity and cancels it.
    assign timeout  = count_en & tick & (idle_cnt == IDLE_LAST)
                    & ~(|btn_pedge);

    // Inactivity counter, cleared by any activity or mode change.
    always_ff @(posedge clk) begin
        if (reset_p) begin
            idle_cnt <= '0;
        end else if ((|btn_pedge) || (mode_d != mode_q) || !count_en) begin
            idle_cnt <= '0;
        end else if (tick) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    localparam int unused_idle_ms = IDLE_TIMEOUT_MS;
    logic unused_sw_running;

    assign unused_sw_running = sw_running;
    assign timeout           = 1'b0;
`endif

    // Buzzer: on at alarm rise, toggles every BUZ_HALF_MS ticks, off when
    // the alarm drops.
    always_ff @(posedge clk) begin
        if (reset_p) begin
            buz     <= 1'b0;
            buz_cnt <= '0;
        end else if (alarm_rise) begin
            buz     <= 1'b1;
            buz_cnt <= '0;
        end else if (alarm_in) begin
            if (tick) begin
                if (buz_cnt == BUZ_LAST) begin
                    buz     <= ~buz;
                    buz_cnt <= '0;
                end else begin
                    buz_cnt <= buz_cnt + 1'b1;
                end
            end
        end else begin
            buz     <= 1'b0;
            buz_cnt <= '0;
        end
    end

endmodule
